lc_tune_sequencer: RTL
======================

# lc_tune_sequencer

Digital sweep controller for a tunable lumped LC match: a binary-weighted capacitor bank plus a tapped inductor. It steps every (inductor tap, capacitor code) pair, waits a settle interval, and requests one measurement from an external detector over a req/ack handshake. It keeps the best-scoring pair and leaves the bank programmed to it. It sits between the tuning-network device models and the measurement/control logic of a mixed-signal bench.

## Interface
- CW, 6, capacitor code width; bank has 2^CW settings
- LW, 2, inductor tap select width; 2^LW taps
- MW, 12, measurement metric width, unsigned
- SETTLE, 8, settle cycles after each code change; legal range 1..255, elaboration error otherwise
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  begin sweep; sampled only in IDLE
- abort  in  1  cancel sweep; sampled in every non-IDLE state
- cap_code  out  CW  capacitor bank setting, registered
- ind_tap  out  LW  inductor tap setting, registered
- meas_req  out  1  measurement request, level
- meas_ack  in  1  measurement complete; meas_val valid this cycle
- meas_val  in  MW  metric, larger is better
- busy  out  1  high from the cycle after accepted start until DONE/abort
- done  out  1  one-cycle pulse, sweep completed normally
- best_cap  out  CW  capacitor code of best point so far
- best_ind  out  LW  tap of best point so far
- best_metric  out  MW  best metric so far

## Operation
- States: IDLE, SETTLE, MEAS, DONE.
- IDLE: busy=0, meas_req=0, cap_code and ind_tap hold their last value.
  - start=1: go to SETTLE. Set cap_code=0, ind_tap=0, best_*=0, busy=1, settle counter=SETTLE-1, first-point flag=1.
- SETTLE: decrement the counter each cycle. Go to MEAS in the cycle the counter is 0 (exactly SETTLE cycles in SETTLE).
- MEAS: meas_req=1, held until a cycle with meas_ack=1.
  - On that edge, capture meas_val.
  - Update best_* if first-point flag=1 or meas_val > best_metric (strict; ties keep the earlier point). Clear the flag.
  - meas_req drops the next cycle.
  - Not last point: advance the code, cap_code inner and ind_tap outer. cap_code wraps 2^CW-1 -> 0 with ind_tap+1. Reload the counter and go to SETTLE.
  - Last point (cap_code and ind_tap all ones): go to DONE.
- DONE (one cycle): cap_code<=best_cap, ind_tap<=best_ind, done=1, busy=0. Then IDLE.
- Best tracking uses the values after any update on the final ack, so a final point that wins is applied.
- meas_ack outside MEAS is ignored. start outside IDLE is ignored.
- abort (non-IDLE, highest priority over ack and counter):
  - Go to IDLE next cycle with busy=0, meas_req=0, no done pulse.
  - cap_code/ind_tap <= best_cap/best_ind, or 0/0 if no point has been measured yet.
  - best_* keep their values.
- Total points: 2^(CW+LW). Arithmetic is unsigned; the counter width is 8 bits.

## Timing
- Reset (async assert, sync deassert by the environment) gives: state IDLE, cap_code=0, ind_tap=0, meas_req=0, busy=0, done=0, best_cap=0, best_ind=0, best_metric=0.
- Reset mid-sweep behaves the same; no done pulse.
- start sampled at edge k: busy=1 and codes=0 from k+1. meas_req rises at k+1+SETTLE.
- With meas_ack tied to meas_req, each point costs SETTLE+1 cycles. Sweep to done pulse: 2^(CW+LW)·(SETTLE+1)+1 cycles after the start edge.
- New codes appear the cycle after the ack edge. meas_req is never high in the same cycle as a code change.
- done and busy never high together. done and the final applied codes are coincident.
- start asserted in the done cycle is ignored. start in the following IDLE cycle is accepted.

## Test plan
- Reset: assert rst_n=0 mid-SETTLE -> all outputs zero immediately, no done. After release, start works normally.
- Full sweep, CW=3, LW=1, SETTLE=4, ack=req, meas_val = 100 at (ind=1, cap=5), else 10 -> 16 meas_req pulses, done at cycle 81 after start, final cap_code=5, ind_tap=1, best_metric=100.
- Tie handling: meas_val=50 at points 2 and 9, others 0 -> best_cap=2, best_ind=0.
- Stalled ack: delay meas_ack 7 cycles on every point -> meas_req held high 8 cycles each, codes stable, result unchanged from the ack=req case.
- Abort: assert abort in the MEAS of point 6 (best so far cap=3) with ack also high -> ack ignored, IDLE next cycle, cap_code=3, no done. Abort during the first SETTLE -> cap_code=0, ind_tap=0.
- Ignored inputs: pulse start while busy and meas_ack during SETTLE -> no state, code, or best change.

Source files
------------

// File: rtl/lc_tune_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : lc_tune_sequencer
// Brief    : Sweeps every (inductor tap, capacitor code) pair of an LC match,
//            measures each point over req/ack and applies the best one.
// Revision : 1.0 - initial release
// ============================================================================
module lc_tune_sequencer #(
    parameter int CW     = 6,
    parameter int LW     = 2,
    parameter int MW     = 12,
    parameter int SETTLE = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    output logic [CW-1:0] cap_code,
    output logic [LW-1:0] ind_tap,
    output logic          meas_req,
    input  logic          meas_ack,
    input  logic [MW-1:0] meas_val,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] best_cap,
    output logic [LW-1:0] best_ind,
    output logic [MW-1:0] best_metric
);

    generate
        if (SETTLE < 1 || SETTLE > 255) begin : g_settle_check
            $error("lc_tune_sequencer: SETTLE must be in 1..255");
        end
    endgenerate

    localparam logic [7:0] c_settle_load = 8'(SETTLE - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_MEAS   = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [7:0]           r_cnt;
    logic                 r_first;
    logic [CW-1:0]        r_cap;
    logic [LW-1:0]        r_ind;
    logic [CW-1:0]        r_best_cap;
    logic [LW-1:0]        r_best_ind;
    logic [MW-1:0]        r_best_metric;

    logic                 w_last;
    logic                 w_win;
    logic [LW+CW-1:0]     w_pt_next;

    assign w_last    = (&r_cap) && (&r_ind);
    assign w_win     = r_first || (meas_val > r_best_metric);
    // Tap is the outer loop: carry out of the cap code steps the tap.
    assign w_pt_next = {r_ind, r_cap} + {{(LW+CW-1){1'b0}}, 1'b1};

    assign cap_code    = r_cap;
    assign ind_tap     = r_ind;
    assign best_cap    = r_best_cap;
    assign best_ind    = r_best_ind;
    assign best_metric = r_best_metric;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        meas_req    = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_SETTLE;
                end
            end
            S_SETTLE: begin
                busy = 1'b1;
                if (abort) begin
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == 8'd0) begin
                    w_state_nxt = S_MEAS;
                end
            end
            S_MEAS: begin
                busy     = 1'b1;
                meas_req = 1'b1;
                if (abort) begin
                    w_state_nxt = S_IDLE;
                end else if (meas_ack) begin
                    w_state_nxt = w_last ? S_DONE : S_SETTLE;
                end
            end
            S_DONE: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt         <= 8'd0;
            r_first       <= 1'b0;
            r_cap         <= '0;
            r_ind         <= '0;
            r_best_cap    <= '0;
            r_best_ind    <= '0;
            r_best_metric <= '0;
        end else if (r_state == S_IDLE) begin
            if (start) begin
                r_cnt         <= c_settle_load;
                r_first       <= 1'b1;
                r_cap         <= '0;
                r_ind         <= '0;
                r_best_cap    <= '0;
                r_best_ind    <= '0;
                r_best_metric <= '0;
            end
        end else if (abort) begin
            if (r_first) begin
                r_cap <= '0;
                r_ind <= '0;
            end else begin
                r_cap <= r_best_cap;
                r_ind <= r_best_ind;
            end
        end else if (r_state == S_SETTLE) begin
            if (r_cnt != 8'd0) begin
                r_cnt <= r_cnt - 8'd1;
            end
        end else if (r_state == S_MEAS && meas_ack) begin
            r_first <= 1'b0;
            if (w_win) begin
                r_best_cap    <= r_cap;
                r_best_ind    <= r_ind;
                r_best_metric <= meas_val;
            end
            if (w_last) begin
                // Apply the winner now so it is already on the bank during DONE.
                r_cap <= w_win ? r_cap : r_best_cap;
                r_ind <= w_win ? r_ind : r_best_ind;
            end else begin
                {r_ind, r_cap} <= w_pt_next;
                r_cnt          <= c_settle_load;
            end
        end
    end

endmodule
`default_nettype wire
